// File: rtl/power_stim_sequencer.sv
// Stimulus/handshake sequencer for power-analysis traces: LFSR or fixed blocks,
// TVLA alternation, core load/busy handshake. Optional macro: POWER_STIM_TIMEOUT_EN.
module power_stim_sequencer #(
  parameter int unsigned       DATA_W     = 128,
  parameter int unsigned       LFSR_W     = 32,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 32'h80200003,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 32'hACE1ACE1,
  parameter int unsigned       GAP_CYCLES = 256,
  parameter int unsigned       CNT_W      = 16
`ifdef POWER_STIM_TIMEOUT_EN
  , parameter int unsigned     BUSY_TIMEOUT = 1024
`endif
) (
  input  logic              ICE_CLK,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fixed_text,
  output logic              core_load,
  output logic [DATA_W-1:0] core_data,
  input  logic              core_busy,
  input  logic [DATA_W-1:0] core_result,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic              result_fixed,
  output logic [CNT_W-1:0]  trace_count,
  output logic              active
`ifdef POWER_STIM_TIMEOUT_EN
  , output logic            error
`endif
);

  localparam int unsigned REP   = DATA_W / LFSR_W;
  localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_LOAD, S_START, S_WAIT, S_RUN, S_CAPTURE
  } state_t;

  state_t              r_state;
  logic [GAP_W-1:0]    r_gap;
  logic [LFSR_W-1:0]   r_lfsr;
  logic                r_sel;
  logic                r_fixed;
  logic                r_alt;
  logic                r_core_load;
  logic [DATA_W-1:0]   r_core_data;
  logic                r_result_valid;
  logic [DATA_W-1:0]   r_result;
  logic                r_result_fixed;
  logic [CNT_W-1:0]    r_count;
  logic                r_active;
  logic                w_halt;
  logic                w_load_fixed;
  logic [LFSR_W-1:0]   w_lfsr_next;
  logic [DATA_W-1:0]   w_rand;

`ifdef POWER_STIM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(BUSY_TIMEOUT + 8);
  logic [TO_W-1:0] r_to;
  logic            r_error;
  assign w_halt = r_error;
  assign error  = r_error;
`else
  assign w_halt = 1'b0;
`endif

  assign w_lfsr_next  = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
  assign w_rand       = {REP{r_lfsr}};
  assign w_load_fixed = (mode == 2'd1) || ((mode == 2'd2) && r_sel);

  always_ff @(posedge ICE_CLK) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_gap          <= '0;
      r_lfsr         <= LFSR_SEED;
      r_sel          <= 1'b1;
      r_fixed        <= 1'b0;
      r_alt          <= 1'b0;
      r_core_load    <= 1'b0;
      r_core_data    <= '0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_result_fixed <= 1'b0;
      r_count        <= '0;
      r_active       <= 1'b0;
`ifdef POWER_STIM_TIMEOUT_EN
      r_to           <= '0;
      r_error        <= 1'b0;
`endif
    end else begin
      r_core_load    <= 1'b0;
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable && !w_halt) begin
            r_state  <= S_GAP;
            r_gap    <= '0;
            r_active <= 1'b1;
          end
        end
        S_GAP: begin
          if (!enable) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end else if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
            r_state <= S_LOAD;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        S_LOAD: begin
          r_core_data <= w_load_fixed ? fixed_text : w_rand;
          r_fixed     <= w_load_fixed;
          r_alt       <= (mode == 2'd2);
          r_core_load <= 1'b1;
          r_state     <= S_START;
        end
        S_START: begin
          r_state <= S_WAIT;
`ifdef POWER_STIM_TIMEOUT_EN
          r_to    <= '0;
`endif
        end
        S_WAIT: begin
          if (core_busy) begin
            r_state <= S_RUN;
`ifdef POWER_STIM_TIMEOUT_EN
            r_to    <= '0;
          end else if (r_to == TO_W'(7)) begin
            r_error  <= 1'b1;
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end else begin
            r_to <= r_to + 1'b1;
`endif
          end
        end
        S_RUN: begin
          // Capture side effects land on the edge into CAPTURE so that
          // result, result_valid, result_fixed and trace_count update together.
          if (!core_busy) begin
            r_result       <= core_result;
            r_result_valid <= 1'b1;
            r_result_fixed <= r_fixed;
            r_count        <= r_count + 1'b1;
            r_lfsr         <= w_lfsr_next;
            if (r_alt) r_sel <= ~r_sel;
            r_state        <= S_CAPTURE;
`ifdef POWER_STIM_TIMEOUT_EN
          end else if (r_to == TO_W'(BUSY_TIMEOUT - 1)) begin
            r_error  <= 1'b1;
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end else begin
            r_to <= r_to + 1'b1;
`endif
          end
        end
        S_CAPTURE: begin
          if (enable) begin
            r_state <= S_GAP;
            r_gap   <= '0;
          end else begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign core_load    = r_core_load;
  assign core_data    = r_core_data;
  assign result_valid = r_result_valid;
  assign result       = r_result;
  assign result_fixed = r_result_fixed;
  assign trace_count  = r_count;
  assign active       = r_active;

endmodule

// File: tb/tb_power_stim_sequencer.sv
// Self-checking bench for power_stim_sequencer: core model plus a trace-level
// reference of the LFSR, alternation and trace counting.
module tb_power_stim_sequencer;

  localparam logic [127:0] KEY = 128'hDEADBEEF_0F1E2D3C_4B5A6978_8796A5B4;

  logic         ICE_CLK;
  logic         rst;
  logic         enable;
  logic [1:0]   mode;
  logic [127:0] fixed_text;
  logic         core_load;
  logic [127:0] core_data;
  logic         core_busy = 1'b0;
  logic [127:0] core_result = '0;
  logic         result_valid;
  logic [127:0] result;
  logic         result_fixed;
  logic [3:0]   trace_count;
  logic         active;
`ifdef POWER_STIM_TIMEOUT_EN
  logic         error;
`endif

  int total = 0;
  int bad   = 0;

  // reference state
  logic [31:0] m_lfsr;
  bit          m_sel;
  int          m_count;

  // core model
  logic pend = 1'b0;
  int   left = 0;
  int   busy_len = 10;
  bit   no_busy = 0;

  power_stim_sequencer #(
    .DATA_W(128), .LFSR_W(32), .LFSR_TAPS(32'h80200003), .LFSR_SEED(32'hACE1ACE1),
    .GAP_CYCLES(4), .CNT_W(4)
  ) dut (
    .ICE_CLK(ICE_CLK), .rst(rst), .enable(enable), .mode(mode), .fixed_text(fixed_text),
    .core_load(core_load), .core_data(core_data), .core_busy(core_busy),
    .core_result(core_result), .result_valid(result_valid), .result(result),
    .result_fixed(result_fixed), .trace_count(trace_count), .active(active)
`ifdef POWER_STIM_TIMEOUT_EN
    , .error(error)
`endif
  );

  initial ICE_CLK = 1'b0;
  always #5 ICE_CLK = ~ICE_CLK;

  always @(posedge ICE_CLK) begin
    if (rst) begin
      pend      <= 1'b0;
      core_busy <= 1'b0;
    end else begin
      pend <= core_load && !no_busy;
      if (core_load) core_result <= core_data ^ KEY;
      if (pend) begin
        core_busy <= 1'b1;
        left      <= busy_len - 1;
      end else if (core_busy) begin
        if (left == 0) core_busy <= 1'b0;
        else left <= left - 1;
      end
    end
  end

  function automatic logic [31:0] ref_next(input logic [31:0] s);
    int c;
    c = $countones(s & 32'h80200003);
    return (s << 1) | 32'(c % 2);
  endfunction

  function automatic bit exp_fixed(input logic [1:0] m);
    return (m == 2'd1) || (m == 2'd2 && m_sel);
  endfunction

  function automatic logic [127:0] exp_block(input bit f, input logic [127:0] ft);
    return f ? ft : {m_lfsr, m_lfsr, m_lfsr, m_lfsr};
  endfunction

  task automatic m_advance(input logic [1:0] m);
    m_lfsr = ref_next(m_lfsr);
    if (m == 2'd2) m_sel = !m_sel;
    m_count++;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0;
    repeat (2) @(negedge ICE_CLK);
    rst = 1'b0;
    m_lfsr = 32'hACE1ACE1; m_sel = 1; m_count = 0;
  endtask

  task automatic wait_sig(input int which, input int limit, output bit ok, output int n);
    ok = 0; n = 0;
    while (!ok && n < limit) begin
      @(negedge ICE_CLK);
      n++;
      case (which)
        0:       ok = core_load;
        1:       ok = result_valid;
        default: ok = core_busy;
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; mode = 2'd0; fixed_text = '0;
    repeat (3) @(negedge ICE_CLK);
    total++; if ({core_load, result_valid, result_fixed, active} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {core_load, result_valid, result_fixed, active}); end
    total++; if (core_data !== '0) begin bad++; $display("FAIL reset_core_data got=%h want=0", core_data); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (trace_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", trace_count); end
    rst = 1'b0;
    m_lfsr = 32'hACE1ACE1; m_sel = 1; m_count = 0;
    repeat (3) @(negedge ICE_CLK);
    total++; if (active !== 1'b0) begin bad++; $display("FAIL idle_active got=%b want=0", active); end
  endtask

  task automatic test_random();
    bit ok; int n; bit ef; logic [127:0] ed; logic [127:0] k;
    do_reset(); mode = 2'd0; busy_len = 10; enable = 1'b1;
    for (int t = 0; t < 2; t++) begin
      wait_sig(0, 200, ok, n);
      total++; if (!ok) begin bad++; $display("FAIL rnd_load t=%0d got=none after %0d want=pulse", t, n); end
      ef = exp_fixed(mode); ed = exp_block(ef, fixed_text);
      total++; if (core_data !== ed) begin bad++; $display("FAIL rnd_data t=%0d got=%h want=%h", t, core_data, ed); end
      k = (t == 0) ? {4{32'hACE1ACE1}} : {4{32'h59C359C3}};
      total++; if (core_data !== k) begin bad++; $display("FAIL rnd_const t=%0d got=%h want=%h", t, core_data, k); end
      @(negedge ICE_CLK);
      total++; if (core_load !== 1'b0) begin bad++; $display("FAIL rnd_load_width t=%0d got=%b want=0", t, core_load); end
      wait_sig(1, 200, ok, n);
      total++; if (!ok) begin bad++; $display("FAIL rnd_valid t=%0d got=none after %0d want=pulse", t, n); end
      total++; if (result !== (ed ^ KEY)) begin bad++; $display("FAIL rnd_result t=%0d got=%h want=%h", t, result, ed ^ KEY); end
      m_advance(mode);
      total++; if (trace_count !== 4'(m_count)) begin bad++; $display("FAIL rnd_count t=%0d got=%0d want=%0d", t, trace_count, 4'(m_count)); end
    end
  endtask

  task automatic test_timing();
    bit ok; int n; int k; logic b1, b2;
    do_reset(); mode = 2'd0; busy_len = 10; enable = 1'b1;
    wait_sig(0, 200, ok, n);
    total++; if (!ok) begin bad++; $display("FAIL tim_load got=none want=pulse"); end
    b1 = 1'b0; b2 = 1'b0; k = 0;
    for (int i = 1; i <= 40; i++) begin
      b2 = b1; b1 = core_busy;
      @(negedge ICE_CLK);
      k = i;
      if (result_valid === 1'b1) break;
    end
    total++; if (k != 13) begin bad++; $display("FAIL tim_load_to_valid got=%0d want=13", k); end
    total++; if ({b2, b1} !== 2'b10) begin bad++; $display("FAIL tim_busy_fall got=%b want=10", {b2, b1}); end
    m_advance(mode);
    wait_sig(0, 40, ok, n);
    total++; if (!ok || n != 6) begin bad++; $display("FAIL tim_gap_to_load got=%0d want=6", n); end
    total++; if (active !== 1'b1) begin bad++; $display("FAIL tim_active got=%b want=1", active); end
    wait_sig(1, 200, ok, n);
    m_advance(mode);
  endtask

  task automatic test_alternate();
    bit ok; int n; bit ef; logic [127:0] ed; logic [127:0] k;
    do_reset(); mode = 2'd2; busy_len = 10;
    fixed_text = 128'h00112233445566778899aabbccddeeff; enable = 1'b1;
    k = {4{32'h59C359C3}};
    for (int t = 0; t < 4; t++) begin
      wait_sig(0, 200, ok, n);
      total++; if (!ok) begin bad++; $display("FAIL alt_load t=%0d got=none want=pulse", t); end
      ef = exp_fixed(mode); ed = exp_block(ef, fixed_text);
      total++; if (core_data !== ed) begin bad++; $display("FAIL alt_data t=%0d got=%h want=%h", t, core_data, ed); end
      if (t == 1) begin
        total++; if (core_data !== k) begin bad++; $display("FAIL alt_second_rand got=%h want=%h", core_data, k); end
      end
      wait_sig(1, 200, ok, n);
      total++; if (!ok) begin bad++; $display("FAIL alt_valid t=%0d got=none want=pulse", t); end
      total++; if (result_fixed !== ((t % 2) == 0)) begin bad++; $display("FAIL alt_fixed t=%0d got=%b want=%b", t, result_fixed, (t % 2) == 0); end
      total++; if (result !== (ed ^ KEY)) begin bad++; $display("FAIL alt_result t=%0d got=%h want=%h", t, result, ed ^ KEY); end
      m_advance(mode);
    end
  endtask

  task automatic test_enable_drop();
    bit ok; int n; bit seen; logic [127:0] ed;
    do_reset(); mode = 2'd0; busy_len = 10; enable = 1'b1;
    wait_sig(0, 200, ok, n);
    ed = exp_block(exp_fixed(mode), fixed_text);
    wait_sig(2, 50, ok, n);
    total++; if (!ok) begin bad++; $display("FAIL drop_busy got=none want=busy"); end
    enable = 1'b0;
    wait_sig(1, 200, ok, n);
    total++; if (!ok) begin bad++; $display("FAIL drop_valid got=none want=pulse"); end
    total++; if (result !== (ed ^ KEY)) begin bad++; $display("FAIL drop_result got=%h want=%h", result, ed ^ KEY); end
    m_advance(mode);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ICE_CLK);
      if (active !== 1'b0 || core_load !== 1'b0) seen = 1;
    end
    total++; if (seen) begin bad++; $display("FAIL drop_idle got=activity want=idle"); end
    enable = 1'b1;
    wait_sig(0, 200, ok, n);
    ed = exp_block(exp_fixed(mode), fixed_text);
    total++; if (core_data !== ed) begin bad++; $display("FAIL drop_resume_data got=%h want=%h", core_data, ed); end
    wait_sig(1, 200, ok, n);
    m_advance(mode);
    total++; if (trace_count !== 4'(m_count)) begin bad++; $display("FAIL drop_resume_count got=%0d want=%0d", trace_count, 4'(m_count)); end
  endtask

  task automatic test_rst_run();
    bit ok; int n; logic [127:0] k;
    do_reset(); mode = 2'd0; busy_len = 10; enable = 1'b1;
    wait_sig(1, 300, ok, n);
    m_advance(mode);
    wait_sig(0, 200, ok, n);
    wait_sig(2, 50, ok, n);
    @(negedge ICE_CLK);
    rst = 1'b1;
    @(negedge ICE_CLK);
    rst = 1'b0;
    m_lfsr = 32'hACE1ACE1; m_sel = 1; m_count = 0;
    total++; if ({core_load, result_valid, result_fixed, active} !== 4'b0) begin
      bad++; $display("FAIL rst_flags got=%b want=0000", {core_load, result_valid, result_fixed, active}); end
    total++; if (core_data !== '0 || result !== '0) begin bad++; $display("FAIL rst_data got=%h/%h want=0/0", core_data, result); end
    total++; if (trace_count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", trace_count); end
    wait_sig(0, 200, ok, n);
    k = {4{32'hACE1ACE1}};
    total++; if (core_data !== k) begin bad++; $display("FAIL rst_next_data got=%h want=%h", core_data, k); end
    wait_sig(1, 200, ok, n);
    m_advance(mode);
    total++; if (trace_count !== 4'd1) begin bad++; $display("FAIL rst_next_count got=%0d want=1", trace_count); end
  endtask

  task automatic test_random_stream();
    bit ok; int n; bit ef; logic [127:0] ed; logic [1:0] tm;
    do_reset();
    mode = 2'($urandom_range(0, 3)); busy_len = $urandom_range(1, 12);
    fixed_text = {$urandom, $urandom, $urandom, $urandom}; enable = 1'b1;
    for (int t = 0; t < 20; t++) begin
      wait_sig(0, 200, ok, n);
      total++; if (!ok) begin bad++; $display("FAIL str_load t=%0d got=none want=pulse", t); end
      tm = mode;
      ef = exp_fixed(tm); ed = exp_block(ef, fixed_text);
      total++; if (core_data !== ed) begin bad++; $display("FAIL str_data t=%0d mode=%0d got=%h want=%h", t, tm, core_data, ed); end
      wait_sig(1, 200, ok, n);
      total++; if (!ok || result !== (ed ^ KEY) || result_fixed !== ef) begin
        bad++; $display("FAIL str_result t=%0d got=%h/%b want=%h/%b", t, result, result_fixed, ed ^ KEY, ef); end
      m_advance(tm);
      total++; if (trace_count !== 4'(m_count)) begin bad++; $display("FAIL str_count t=%0d got=%0d want=%0d", t, trace_count, 4'(m_count)); end
      mode = 2'($urandom_range(0, 3)); busy_len = $urandom_range(1, 12);
      fixed_text = {$urandom, $urandom, $urandom, $urandom};
    end
    enable = 1'b0;
  endtask

`ifdef POWER_STIM_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int n; bit seen;
    do_reset(); mode = 2'd0; no_busy = 1; enable = 1'b1;
    wait_sig(0, 200, ok, n);
    n = 0;
    while (error !== 1'b1 && n < 40) begin
      @(negedge ICE_CLK);
      n++;
    end
    total++; if (n != 9) begin bad++; $display("FAIL to_error_delay got=%0d want=9", n); end
    total++; if (trace_count !== 4'd0) begin bad++; $display("FAIL to_count got=%0d want=0", trace_count); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ICE_CLK);
      if (active !== 1'b0 || core_load !== 1'b0 || error !== 1'b1) seen = 1;
    end
    total++; if (seen) begin bad++; $display("FAIL to_stuck_idle got=activity want=idle"); end
    no_busy = 0;
    do_reset();
    total++; if (error !== 1'b0) begin bad++; $display("FAIL to_rst_clear got=%b want=0", error); end
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'd0; fixed_text = '0;
    test_reset();
    test_random();
    test_timing();
    test_alternate();
    test_enable_drop();
    test_rst_run();
    test_random_stream();
`ifdef POWER_STIM_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
